// File: rtl/photon_beetle_pkg.sv
// ----------------------------------------------------------------------------
// photon_beetle_pkg : shared types and constants for the PHOTON-Beetle hash ctrl
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package photon_beetle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD1 = 3'd2,
        ST_PAD1  = 3'd3,
        ST_PERM  = 3'd4,
        ST_LOADR = 3'd5,
        ST_CONST = 3'd6,
        ST_SQ    = 3'd7
    } state_t;

    // Where the permutation hands control back to once its 12 rounds finish
    typedef enum logic [1:0] {
        PH_LOADR = 2'd0,
        PH_SQ0   = 2'd1,
        PH_SQ1   = 2'd2
    } phase_t;

    localparam int         ROUNDS       = 12;
    localparam int         FIRST_LANES  = 4;
    localparam logic [1:0] CONST_PADDED = 2'd1;
    localparam logic [1:0] CONST_FULL   = 2'd2;

    // Byte counts of 0 or above 4 on a last beat are taken as a full word
    function automatic logic [2:0] eff_bytes(input logic [2:0] bytes);
        return ((bytes == 3'd0) || (bytes > 3'd4)) ? 3'd4 : bytes;
    endfunction

endpackage

`default_nettype wire

// File: rtl/photon_pad_word.sv
// ----------------------------------------------------------------------------
// photon_pad_word : inserts the 0x01 pad byte into a short final beat
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module photon_pad_word
    import photon_beetle_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  bytes,
    input  logic        last,
    output logic [31:0] word
);

    logic [2:0] w_bytes;

    assign w_bytes = eff_bytes(bytes);

    always_comb begin
        word = data;
        if (last && (w_bytes < 3'd4)) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) == w_bytes) begin
                    word[8*k +: 8] = 8'h01;
                end else if (3'(k) > w_bytes) begin
                    word[8*k +: 8] = 8'h00;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/photon_beetle_hash_ctrl.sv
// ----------------------------------------------------------------------------
// photon_beetle_hash_ctrl : sequences clear/absorb/permute/squeeze for the hash
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module photon_beetle_hash_ctrl
    import photon_beetle_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        io_start,
    input  logic        io_empty,
    output logic        io_busy,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [31:0] io_in_data,
    input  logic        io_in_last,
    input  logic [2:0]  io_in_bytes,
    output logic        io_clear,
    output logic        io_absorb_en,
    output logic [1:0]  io_absorb_idx,
    output logic [31:0] io_absorb_data,
    output logic        io_perm_en,
    output logic [3:0]  io_round,
    output logic        io_const_en,
    output logic [1:0]  io_const_val,
    output logic        io_tag_valid,
    input  logic        io_tag_ready,
    output logic        io_tag_half,
    output logic        io_done
);

    localparam logic [3:0] C_LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [1:0] C_LAST_LANE  = 2'(FIRST_LANES - 1);

    state_t      r_state;
    phase_t      r_phase;
    logic [1:0]  r_beat;
    logic [3:0]  r_round;
    logic        r_empty;
    logic        r_busy;
    logic        r_in_ready;
    logic        r_clear;
    logic        r_pad;
    logic        r_perm_en;
    logic        r_const_en;
    logic [1:0]  r_const_val;
    logic        r_tag_valid;
    logic        r_tag_half;

    logic        w_accept;
    logic        w_short;
    logic [31:0] w_padded;

    assign w_accept = r_in_ready & io_in_valid;
    assign w_short  = io_in_last & (eff_bytes(io_in_bytes) != 3'd4);

    photon_pad_word u_pad (
        .data  (io_in_data),
        .bytes (io_in_bytes),
        .last  (io_in_last),
        .word  (w_padded)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_phase     <= PH_LOADR;
            r_beat      <= 2'd0;
            r_round     <= 4'd0;
            r_empty     <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_clear     <= 1'b0;
            r_pad       <= 1'b0;
            r_perm_en   <= 1'b0;
            r_const_en  <= 1'b0;
            r_const_val <= 2'd0;
            r_tag_valid <= 1'b0;
            r_tag_half  <= 1'b0;
        end else begin
            r_clear     <= 1'b0;
            r_pad       <= 1'b0;
            r_const_en  <= 1'b0;
            r_const_val <= 2'd0;
            case (r_state)
                ST_IDLE: begin
                    if (io_start) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_clear <= 1'b1;
                        r_empty <= io_empty;
                        r_beat  <= 2'd0;
                    end
                end
                ST_CLEAR: begin
                    if (r_empty) begin
                        r_state     <= ST_CONST;
                        r_const_en  <= 1'b1;
                        r_const_val <= CONST_PADDED;
                    end else begin
                        r_state    <= ST_LOAD1;
                        r_in_ready <= 1'b1;
                    end
                end
                ST_LOAD1: begin
                    if (w_accept) begin
                        if (io_in_last) begin
                            r_in_ready <= 1'b0;
                            if (w_short) begin
                                r_state     <= ST_CONST;
                                r_const_en  <= 1'b1;
                                r_const_val <= CONST_PADDED;
                                r_beat      <= 2'd0;
                            end else if (r_beat == C_LAST_LANE) begin
                                r_state     <= ST_CONST;
                                r_const_en  <= 1'b1;
                                r_const_val <= CONST_FULL;
                                r_beat      <= 2'd0;
                            end else begin
                                // Full last word with rate space left: pad in the next lane
                                r_state <= ST_PAD1;
                                r_pad   <= 1'b1;
                                r_beat  <= r_beat + 2'd1;
                            end
                        end else if (r_beat == C_LAST_LANE) begin
                            r_in_ready <= 1'b0;
                            r_state    <= ST_PERM;
                            r_phase    <= PH_LOADR;
                            r_perm_en  <= 1'b1;
                            r_round    <= 4'd0;
                            r_beat     <= 2'd0;
                        end else begin
                            r_beat <= r_beat + 2'd1;
                        end
                    end
                end
                ST_PAD1: begin
                    r_state     <= ST_CONST;
                    r_const_en  <= 1'b1;
                    r_const_val <= CONST_PADDED;
                    r_beat      <= 2'd0;
                end
                ST_PERM: begin
                    if (r_round == C_LAST_ROUND) begin
                        r_perm_en <= 1'b0;
                        r_round   <= 4'd0;
                        case (r_phase)
                            PH_LOADR: begin
                                r_state    <= ST_LOADR;
                                r_in_ready <= 1'b1;
                            end
                            PH_SQ0: begin
                                r_state     <= ST_SQ;
                                r_tag_valid <= 1'b1;
                                r_tag_half  <= 1'b0;
                            end
                            default: begin
                                r_state     <= ST_SQ;
                                r_tag_valid <= 1'b1;
                                r_tag_half  <= 1'b1;
                            end
                        endcase
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                ST_LOADR: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (io_in_last) begin
                            r_state     <= ST_CONST;
                            r_const_en  <= 1'b1;
                            r_const_val <= w_short ? CONST_PADDED : CONST_FULL;
                        end else begin
                            r_state   <= ST_PERM;
                            r_phase   <= PH_LOADR;
                            r_perm_en <= 1'b1;
                            r_round   <= 4'd0;
                        end
                    end
                end
                ST_CONST: begin
                    r_state   <= ST_PERM;
                    r_phase   <= PH_SQ0;
                    r_perm_en <= 1'b1;
                    r_round   <= 4'd0;
                end
                ST_SQ: begin
                    if (io_tag_ready) begin
                        r_tag_valid <= 1'b0;
                        if (!r_tag_half) begin
                            r_state   <= ST_PERM;
                            r_phase   <= PH_SQ1;
                            r_perm_en <= 1'b1;
                            r_round   <= 4'd0;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_tag_half <= 1'b0;
                            r_busy     <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_busy        = r_busy;
    assign io_in_ready    = r_in_ready;
    assign io_clear       = r_clear;
    assign io_perm_en     = r_perm_en;
    assign io_round       = r_round;
    assign io_const_en    = r_const_en;
    assign io_const_val   = r_const_val;
    assign io_tag_valid   = r_tag_valid;
    assign io_tag_half    = r_tag_half;
    assign io_absorb_en   = w_accept | r_pad;
    assign io_absorb_idx  = io_absorb_en ? r_beat : 2'd0;
    assign io_absorb_data = r_pad ? 32'h0000_0001 : (w_accept ? w_padded : 32'h0);
    assign io_done        = r_tag_valid & io_tag_ready & r_tag_half;

endmodule

`default_nettype wire
